l2_rr_arbiter: RTL and testbench

- Registered round-robin arbiter sharing the single L2 cache port between the I-cache and D-cache miss paths.
- Fair alternation between the two caches when both are requesting.
- Latches the winner's address/data/op for the whole L2 transaction.
- Returns the line through a registered response stage.
- Sits between the L1 caches and the L2 cache inside the cache hierarchy.

---
 rtl/l2_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_l2_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: shares the single L2 port between the I-cache and D-cache
// miss paths. Round-robin between the two sides, latches the winning request
// for the whole L2 transaction and returns the line through a registered
// one-cycle response stage.
//
// Handshake: a requester holds read/write until it sees its one-cycle resp
// pulse; toward L2 the arbiter holds exactly one strobe until l2mem_resp=1
// and drops it on the following edge. Requests are sampled only in IDLE.
module l2_rr_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] ipmem_address,
   input  logic [LINE_WIDTH-1:0] ipmem_wdata,
   output logic [LINE_WIDTH-1:0] ipmem_rdata,
   input  logic                  ipmem_read,
   input  logic                  ipmem_write,
   output logic                  ipmem_resp,
   input  logic [ADDR_WIDTH-1:0] dpmem_address,
   input  logic [LINE_WIDTH-1:0] dpmem_wdata,
   output logic [LINE_WIDTH-1:0] dpmem_rdata,
   input  logic                  dpmem_read,
   input  logic                  dpmem_write,
   output logic                  dpmem_resp,
   output logic [ADDR_WIDTH-1:0] l2mem_address,
   output logic [LINE_WIDTH-1:0] l2mem_wdata,
   input  logic [LINE_WIDTH-1:0] l2mem_rdata,
   output logic                  l2mem_read,
   output logic                  l2mem_write,
   input  logic                  l2mem_resp,
   output logic                  arb_busy,
   output logic [1:0]            arb_grant,
   output logic [1:0]            arb_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] GR_NONE = 2'b00;
   localparam logic [1:0] GR_I    = 2'b01;
   localparam logic [1:0] GR_D    = 2'b10;

   logic [1:0]            state_q, state_d;
   logic                  ptr_q, ptr_d;      // 0: I-cache favoured, 1: D-cache favoured
   logic [1:0]            grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  l2_read_q, l2_read_d;
   logic                  l2_write_q, l2_write_d;
   logic                  iresp_q, iresp_d;
   logic                  dresp_q, dresp_d;
   logic [LINE_WIDTH-1:0] irdata_q, irdata_d;
   logic [LINE_WIDTH-1:0] drdata_q, drdata_d;

   logic req_i, req_d, pick_d;

   // The I-cache never writes, so its write strobe and write line are dropped.
   logic unused_inputs;
   assign unused_inputs = ^{ipmem_write, ipmem_wdata};

   // Next-state logic: arbitration in IDLE, wait for L2 in BUSY, one-cycle RESP.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      l2_read_d  = l2_read_q;
      l2_write_d = l2_write_q;
      iresp_d    = 1'b0;
      dresp_d    = 1'b0;
      irdata_d   = irdata_q;
      drdata_d   = drdata_q;
      req_i      = ipmem_read;
      req_d      = dpmem_read | dpmem_write;
      pick_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_i || req_d) begin
               pick_d  = req_d && (!req_i || ptr_q);
               state_d = ST_BUSY;
               if (pick_d) begin
                  grant_d    = GR_D;
                  addr_d     = dpmem_address;
                  wdata_d    = dpmem_wdata;
                  // a simultaneous read+write is served as a writeback
                  l2_write_d = dpmem_write;
                  l2_read_d  = ~dpmem_write;
                  ptr_d      = 1'b0;
               end else begin
                  grant_d    = GR_I;
                  addr_d     = ipmem_address;
                  wdata_d    = '0;
                  l2_write_d = 1'b0;
                  l2_read_d  = 1'b1;
                  ptr_d      = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (l2mem_resp) begin
               l2_read_d  = 1'b0;
               l2_write_d = 1'b0;
               state_d    = ST_RESP;
               iresp_d    = (grant_q == GR_I);
               dresp_d    = (grant_q == GR_D);
               if (l2_read_q) begin
                  if (grant_q == GR_I) irdata_d = l2mem_rdata;
                  else                 drdata_d = l2mem_rdata;
               end
            end
         end
         ST_RESP: begin
            grant_d = GR_NONE;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d    = GR_NONE;
            l2_read_d  = 1'b0;
            l2_write_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 1'b0;
         grant_q    <= GR_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
         l2_read_q  <= 1'b0;
         l2_write_q <= 1'b0;
         iresp_q    <= 1'b0;
         dresp_q    <= 1'b0;
         irdata_q   <= '0;
         drdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         l2_read_q  <= l2_read_d;
         l2_write_q <= l2_write_d;
         iresp_q    <= iresp_d;
         dresp_q    <= dresp_d;
         irdata_q   <= irdata_d;
         drdata_q   <= drdata_d;
      end
   end

   assign l2mem_address = addr_q;
   assign l2mem_wdata   = wdata_q;
   assign l2mem_read    = l2_read_q;
   assign l2mem_write   = l2_write_q;
   assign ipmem_resp    = iresp_q;
   assign dpmem_resp    = dresp_q;
   assign ipmem_rdata   = irdata_q;
   assign dpmem_rdata   = drdata_q;
   assign arb_grant     = grant_q;
   assign arb_busy      = (state_q != ST_IDLE);
   assign arb_state     = state_q;

endmodule

// File: tb/tb_l2_rr_arbiter.sv
// tb_l2_rr_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_l2_rr_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] ipmem_address, dpmem_address, l2mem_address;
   logic [LW-1:0] ipmem_wdata, dpmem_wdata, l2mem_wdata;
   logic [LW-1:0] ipmem_rdata, dpmem_rdata, l2mem_rdata;
   logic          ipmem_read, ipmem_write, ipmem_resp;
   logic          dpmem_read, dpmem_write, dpmem_resp;
   logic          l2mem_read, l2mem_write, l2mem_resp;
   logic          arb_busy;
   logic [1:0]    arb_grant, arb_state;

   l2_rr_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .ipmem_address(ipmem_address), .ipmem_wdata(ipmem_wdata), .ipmem_rdata(ipmem_rdata),
      .ipmem_read(ipmem_read), .ipmem_write(ipmem_write), .ipmem_resp(ipmem_resp),
      .dpmem_address(dpmem_address), .dpmem_wdata(dpmem_wdata), .dpmem_rdata(dpmem_rdata),
      .dpmem_read(dpmem_read), .dpmem_write(dpmem_write), .dpmem_resp(dpmem_resp),
      .l2mem_address(l2mem_address), .l2mem_wdata(l2mem_wdata), .l2mem_rdata(l2mem_rdata),
      .l2mem_read(l2mem_read), .l2mem_write(l2mem_write), .l2mem_resp(l2mem_resp),
      .arb_busy(arb_busy), .arb_grant(arb_grant), .arb_state(arb_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   int i_resp_cnt = 0;
   int d_resp_cnt = 0;
   logic [1:0] exp_q[$];

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Transaction view: an owner (0 none, 1 I, 2 D) holds the L2 port while a
   // transaction is active, then gets one response cycle. Fairness is kept as
   // "who was served last".
   int            m_owner = 0;
   int            m_last  = 2;
   bit            m_active = 1'b0, m_done = 1'b0, m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [LW-1:0] m_wdata = '0, m_irdata = '0, m_drdata = '0;

   always @(posedge clk) begin : model
      bit ri, rd;
      int pick;
      if (rst) begin
         m_owner = 0; m_last = 2; m_active = 1'b0; m_done = 1'b0; m_wr = 1'b0;
         m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
      end else if (m_done) begin
         m_done  = 1'b0;
         m_owner = 0;
      end else if (m_active) begin
         if (l2mem_resp) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            if (!m_wr) begin
               if (m_owner == 1) m_irdata = l2mem_rdata;
               else              m_drdata = l2mem_rdata;
            end
         end
      end else begin
         ri = ipmem_read;
         rd = dpmem_read | dpmem_write;
         if (ri || rd) begin
            if (ri && rd) pick = (m_last == 1) ? 2 : 1;
            else          pick = ri ? 1 : 2;
            m_owner  = pick;
            m_last   = pick;
            m_active = 1'b1;
            if (pick == 1) begin
               m_addr = ipmem_address;
               m_wr   = 1'b0;
            end else begin
               m_addr  = dpmem_address;
               m_wr    = dpmem_write;
               m_wdata = dpmem_wdata;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("l2_read",  LW'(l2mem_read),  LW'(m_active && !m_wr));
         check("l2_write", LW'(l2mem_write), LW'(m_active && m_wr));
         if (m_active) check("l2_addr", LW'(l2mem_address), LW'(m_addr));
         if (m_active && m_wr) check("l2_wdata", l2mem_wdata, m_wdata);
         check("i_resp",  LW'(ipmem_resp), LW'(m_done && m_owner == 1));
         check("d_resp",  LW'(dpmem_resp), LW'(m_done && m_owner == 2));
         check("i_rdata", ipmem_rdata, m_irdata);
         check("d_rdata", dpmem_rdata, m_drdata);
         check("busy",    LW'(arb_busy),  LW'(m_active || m_done));
         check("grant",   LW'(arb_grant), LW'(m_owner));
         if (ipmem_resp === 1'b1) i_resp_cnt++;
         if (dpmem_resp === 1'b1) d_resp_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobe(input string name);
      int n;
      n = 0;
      while (!(l2mem_read || l2mem_write) && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!(l2mem_read || l2mem_write)) begin
         errors++;
         $display("FAIL %s_timeout: got no L2 strobe after %0d cycles, required strobe", name, n);
      end
   endtask

   task automatic l2_resp(input int delay, input logic [LW-1:0] data);
      repeat (delay) tick();
      l2mem_resp  = 1'b1;
      l2mem_rdata = data;
      tick();
      l2mem_resp  = 1'b0;
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int j = 0; j < LW / 32; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [LW-1:0] d;
      logic [AW-1:0] ea;
      ipmem_address = '0; ipmem_wdata = '0; ipmem_read = 1'b0; ipmem_write = 1'b0;
      dpmem_address = '0; dpmem_wdata = '0; dpmem_read = 1'b0; dpmem_write = 1'b0;
      l2mem_rdata = '0; l2mem_resp = 1'b0;
      exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};

      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_busy",  LW'(arb_busy),  '0);
      check("rst_grant", LW'(arb_grant), '0);
      check("rst_l2rd",  LW'(l2mem_read | l2mem_write), '0);
      check("rst_resp",  LW'(ipmem_resp | dpmem_resp), '0);
      check("rst_rdata", ipmem_rdata | dpmem_rdata, '0);
      rst = 1'b0;
      tick();

      // Single I read
      i_resp_cnt = 0; d_resp_cnt = 0;
      ipmem_address = 32'h0000_0060;
      ipmem_read = 1'b1;
      tick();
      check("t1_read_t1", LW'(l2mem_read), LW'(1'b1));
      wait_strobe("t1");
      check("t1_addr",  LW'(l2mem_address), LW'(32'h60));
      check("t1_grant", LW'(arb_grant), LW'(2'b01));
      l2_resp(5, {32{8'hA5}});
      check("t1_iresp", LW'(ipmem_resp), LW'(1'b1));
      check("t1_irdata", ipmem_rdata, {32{8'hA5}});
      ipmem_read = 1'b0;
      tick();
      check("t1_pulse", LW'(ipmem_resp), '0);
      check("t1_idle",  LW'(arb_grant), '0);
      check("t1_icnt",  LW'(i_resp_cnt), LW'(1));
      check("t1_dcnt",  LW'(d_resp_cnt), '0);

      // D writeback
      d_resp_cnt = 0;
      dpmem_address = 32'h8000_0040;
      dpmem_wdata   = {8{32'h1234_5678}};
      dpmem_write   = 1'b1;
      wait_strobe("t2");
      check("t2_write", LW'(l2mem_write), LW'(1'b1));
      check("t2_read",  LW'(l2mem_read), '0);
      check("t2_addr",  LW'(l2mem_address), LW'(32'h8000_0040));
      check("t2_wdata", l2mem_wdata, {8{32'h1234_5678}});
      l2_resp(3, rand_line());
      check("t2_dresp",  LW'(dpmem_resp), LW'(1'b1));
      check("t2_drdata", dpmem_rdata, '0);
      dpmem_write = 1'b0;
      tick();
      check("t2_dcnt", LW'(d_resp_cnt), LW'(1));

      // Contention: both held, grants must alternate starting with I
      ipmem_address = 32'h0000_1000;
      dpmem_address = 32'h0000_2000;
      ipmem_read = 1'b1;
      dpmem_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_strobe("t3");
         ea = (exp_q[k] == 2'b01) ? 32'h0000_1000 : 32'h0000_2000;
         check("t3_grant", LW'(arb_grant), LW'(exp_q[k]));
         check("t3_addr",  LW'(l2mem_address), LW'(ea));
         d = rand_line();
         l2_resp(2, d);
         if (exp_q[k] == 2'b01) begin
            check("t3_iresp", LW'({ipmem_resp, dpmem_resp}), LW'(2'b10));
            check("t3_irdata", ipmem_rdata, d);
         end else begin
            check("t3_dresp", LW'({ipmem_resp, dpmem_resp}), LW'(2'b01));
            check("t3_drdata", dpmem_rdata, d);
         end
      end
      ipmem_read = 1'b0;
      dpmem_read = 1'b0;
      tick();

      // Input change while BUSY
      dpmem_address = 32'h0000_0100;
      dpmem_read = 1'b1;
      wait_strobe("t4");
      dpmem_address = 32'h0000_0200;
      repeat (3) begin
         tick();
         check("t4_hold", LW'(l2mem_address), LW'(32'h100));
      end
      d = rand_line();
      l2_resp(0, d);
      check("t4_dresp",  LW'(dpmem_resp), LW'(1'b1));
      check("t4_drdata", dpmem_rdata, d);
      dpmem_read = 1'b0;
      tick();

      // Read+write conflict: writeback wins
      d_resp_cnt = 0;
      dpmem_wdata = rand_line();
      dpmem_read = 1'b1;
      dpmem_write = 1'b1;
      wait_strobe("t5");
      check("t5_write", LW'({l2mem_write, l2mem_read}), LW'(2'b10));
      l2_resp(1, rand_line());
      dpmem_read = 1'b0;
      dpmem_write = 1'b0;
      repeat (3) tick();
      check("t5_dcnt", LW'(d_resp_cnt), LW'(1));

      // Reset mid-BUSY, then a stray L2 response
      ipmem_read = 1'b1;
      wait_strobe("t6");
      rst = 1'b1;
      tick();
      check("t6_strobes", LW'({l2mem_read, l2mem_write}), '0);
      check("t6_resp",    LW'({ipmem_resp, dpmem_resp}), '0);
      check("t6_busy",    LW'(arb_busy), '0);
      check("t6_grant",   LW'(arb_grant), '0);
      check("t6_rdata",   ipmem_rdata | dpmem_rdata, '0);
      rst = 1'b0;
      ipmem_read = 1'b0;
      i_resp_cnt = 0; d_resp_cnt = 0;
      l2_resp(1, rand_line());
      repeat (3) tick();
      check("t6_stray", LW'(i_resp_cnt + d_resp_cnt), '0);
      check("t6_idle",  LW'(arb_busy), '0);

      // Randomized traffic, including stray L2 responses and dropped requests
      for (int c = 0; c < 3000; c++) begin
         ipmem_read    = ($urandom_range(0, 9) < 6);
         ipmem_write   = $urandom_range(0, 1) == 1;
         dpmem_read    = ($urandom_range(0, 9) < 5);
         dpmem_write   = ($urandom_range(0, 9) < 3);
         ipmem_address = $urandom;
         dpmem_address = $urandom;
         ipmem_wdata   = rand_line();
         dpmem_wdata   = rand_line();
         l2mem_resp    = ($urandom_range(0, 3) == 0);
         l2mem_rdata   = rand_line();
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         else                             rst = 1'b0;
         tick();
      end
      ipmem_read = 1'b0; ipmem_write = 1'b0; dpmem_read = 1'b0; dpmem_write = 1'b0;
      l2mem_resp = 1'b0; rst = 1'b0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
